// File: rtl/alu_uart_sequencer_if.sv
// Signal bundle between the byte-stream sequencer and its surroundings:
// the UART RX/TX units and the ALU datapath.
interface alu_uart_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int OP_WIDTH   = 6
);
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_done;
    logic                  tx_busy;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [OP_WIDTH-1:0]   alu_op;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_start;
    logic                  timeout;
    logic                  overrun;

    // Sequencer side
    modport master (
        input  rx_data, rx_done, tx_busy, alu_result,
        output alu_a, alu_b, alu_op, tx_data, tx_start, timeout, overrun
    );

    // Environment side (UART units and ALU)
    modport slave (
        output rx_data, rx_done, tx_busy, alu_result,
        input  alu_a, alu_b, alu_op, tx_data, tx_start, timeout, overrun
    );
endinterface

// File: rtl/alu_uart_sequencer.sv
// Collects operand A, operand B and opcode bytes from the UART receiver,
// presents them to the ALU, latches the result and hands it to the UART
// transmitter. Partial frames are abandoned after TIMEOUT idle cycles;
// bytes arriving while a result is in flight set a sticky overrun flag.
module alu_uart_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int OP_WIDTH   = 6,
    parameter int TIMEOUT    = 1000000,
    parameter int TO_WIDTH   = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_uart_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        EXEC,
        SEND,
        TX_WAIT
    } state_t;

    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT - 1);

    state_t              state;
    logic [TO_WIDTH-1:0] to_cnt;
    // Set once tx_busy has been seen low during the current request, so a
    // still-running previous transfer is not taken as our acknowledge.
    logic                busy_low;

    // Frame sequencing, timeout counting, transmit handshake and overrun flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= WAIT_A;
            to_cnt       <= '0;
            busy_low     <= 1'b0;
            bus.alu_a    <= '0;
            bus.alu_b    <= '0;
            bus.alu_op   <= '0;
            bus.tx_data  <= '0;
            bus.tx_start <= 1'b0;
            bus.timeout  <= 1'b0;
            bus.overrun  <= 1'b0;
        end else begin
            bus.timeout <= 1'b0;
            case (state)
                WAIT_A: begin
                    to_cnt <= '0;
                    if (bus.rx_done) begin
                        bus.alu_a <= bus.rx_data;
                        state     <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (bus.rx_done) begin
                        bus.alu_b <= bus.rx_data;
                        to_cnt    <= '0;
                        state     <= WAIT_OP;
                    end else if (to_cnt == TO_LAST) begin
                        bus.timeout <= 1'b1;
                        to_cnt      <= '0;
                        state       <= WAIT_A;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                WAIT_OP: begin
                    if (bus.rx_done) begin
                        bus.alu_op <= bus.rx_data[OP_WIDTH-1:0];
                        to_cnt     <= '0;
                        state      <= EXEC;
                    end else if (to_cnt == TO_LAST) begin
                        bus.timeout <= 1'b1;
                        to_cnt      <= '0;
                        state       <= WAIT_A;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                EXEC: begin
                    to_cnt       <= '0;
                    bus.tx_data  <= bus.alu_result;
                    bus.tx_start <= 1'b1;
                    busy_low     <= !bus.tx_busy;
                    state        <= SEND;
                end
                SEND: begin
                    to_cnt <= '0;
                    if (bus.tx_busy && busy_low) begin
                        bus.tx_start <= 1'b0;
                        state        <= TX_WAIT;
                    end else if (!bus.tx_busy) begin
                        busy_low <= 1'b1;
                    end
                end
                TX_WAIT: begin
                    to_cnt <= '0;
                    if (!bus.tx_busy) begin
                        state <= WAIT_A;
                    end
                end
                default: begin
                    to_cnt       <= '0;
                    bus.tx_start <= 1'b0;
                    state        <= WAIT_A;
                end
            endcase

            if (bus.rx_done && (state == EXEC || state == SEND || state == TX_WAIT)) begin
                bus.overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Bench for alu_uart_sequencer: directed frames from the test plan followed
// by randomized frames, all checked against a byte-level frame model.
module tb_alu_uart_sequencer;

    localparam int DW = 8;
    localparam int OW = 6;
    localparam int TO = 16;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    logic exp_overrun;

    alu_uart_sequencer_if #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) bus ();

    alu_uart_sequencer #(
        .DATA_WIDTH(DW),
        .OP_WIDTH  (OW),
        .TIMEOUT   (TO),
        .TO_WIDTH  (5)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Behavioural ALU: selects an operation from the low opcode bits
    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        case (op[2:0])
            3'd0:    return a + b;
            3'd1:    return a & b;
            3'd2:    return a - b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a;
            3'd6:    return b;
            default: return ~a;
        endcase
    endfunction

    assign bus.alu_result = alu_ref(bus.alu_a, bus.alu_b, bus.alu_op);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got running, expected finished)");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Presents one byte for one cycle; returns on the negedge after capture
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        @(negedge clk);
        bus.rx_done = 1'b0;
    endtask

    // Sends the opcode byte and checks the 2-cycle start latency and result
    task automatic send_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb);
        send_byte(opb);
        check("alu_op", 8'(bus.alu_op), 8'(opb[5:0]));
        check("tx_start_lat1", 8'(bus.tx_start), 8'd0);
        @(negedge clk);
        check("tx_start_lat2", 8'(bus.tx_start), 8'd1);
        check("tx_data", bus.tx_data, alu_ref(a, b, opb[5:0]));
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                         input int unsigned gap);
        send_byte(a);
        check("alu_a", bus.alu_a, a);
        idle(gap);
        send_byte(b);
        check("alu_b", bus.alu_b, b);
        check("alu_a_hold", bus.alu_a, a);
        idle(gap);
        send_op(a, b, opb);
    endtask

    // Completes the transmit handshake from a negedge where tx_start is high
    task automatic finish_tx(input int unsigned dly, input int unsigned len);
        repeat (dly) @(negedge clk);
        check("tx_start_hold", 8'(bus.tx_start), 8'd1);
        bus.tx_busy = 1'b1;
        @(negedge clk);
        check("tx_start_drop", 8'(bus.tx_start), 8'd0);
        repeat (len) @(negedge clk);
        bus.tx_busy = 1'b0;
        @(negedge clk);
        check("overrun", 8'(bus.overrun), 8'(exp_overrun));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_alu_a"}, bus.alu_a, 8'd0);
        check({tag, "_alu_b"}, bus.alu_b, 8'd0);
        check({tag, "_alu_op"}, 8'(bus.alu_op), 8'd0);
        check({tag, "_tx_data"}, bus.tx_data, 8'd0);
        check({tag, "_tx_start"}, 8'(bus.tx_start), 8'd0);
        check({tag, "_timeout"}, 8'(bus.timeout), 8'd0);
        check({tag, "_overrun"}, 8'(bus.overrun), 8'd0);
    endtask

    initial begin
        logic [7:0] a, b, opb, held;
        int         seen;

        checks      = 0;
        errors      = 0;
        exp_overrun = 1'b0;
        rst_n       = 1'b0;
        bus.rx_data = '0;
        bus.rx_done = 1'b0;
        bus.tx_busy = 1'b0;

        idle(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        idle(2);

        // Basic frame: 5 + 3, bytes 10 cycles apart
        frame(8'h05, 8'h03, 8'h20, 8);
        check("add_result", bus.tx_data, 8'h08);
        finish_tx(2, 3);

        // Upper opcode bits are discarded
        frame(8'h10, 8'h04, 8'hE2, 3);
        check("op_trunc", 8'(bus.alu_op), 8'h22);
        finish_tx(1, 2);

        // Abandoned frame: timeout pulse 16 cycles after entering WAIT_B
        send_byte(8'h11);
        seen = 0;
        for (int i = 1; i <= 40 && seen == 0; i++) begin
            @(negedge clk);
            if (bus.timeout) seen = i;
        end
        check("timeout_cycle", 8'(seen), 8'd16);
        @(negedge clk);
        check("timeout_pulse_end", 8'(bus.timeout), 8'd0);
        check("timeout_keeps_a", bus.alu_a, 8'h11);
        frame(8'h01, 8'h02, 8'h24, 4);
        check("fresh_a", bus.alu_a, 8'h01);
        finish_tx(1, 1);

        // Byte arriving on the expiry cycle is accepted, no timeout
        send_byte(8'h33);
        idle(14);
        send_byte(8'h44);
        check("expiry_byte_wins_b", bus.alu_b, 8'h44);
        check("expiry_no_timeout", 8'(bus.timeout), 8'd0);
        idle(2);
        send_op(8'h33, 8'h44, 8'h20);
        finish_tx(1, 1);

        // Byte during SEND: overrun set, result unchanged
        frame(8'h21, 8'h12, 8'h22, 2);
        held = alu_ref(8'h21, 8'h12, 6'h22);
        send_byte(8'h99);
        exp_overrun = 1'b1;
        check("overrun_set", 8'(bus.overrun), 8'd1);
        check("overrun_tx_data", bus.tx_data, held);
        check("overrun_tx_start", 8'(bus.tx_start), 8'd1);
        finish_tx(2, 3);
        frame(8'h0A, 8'h05, 8'h21, 2);
        finish_tx(1, 2);
        check("overrun_sticky", 8'(bus.overrun), 8'd1);

        // tx_busy still high from a previous transfer when SEND is entered
        send_byte(8'h40);
        send_byte(8'h02);
        bus.tx_busy = 1'b1;
        send_op(8'h40, 8'h02, 8'h23);
        idle(8);
        check("busy_entry_hold", 8'(bus.tx_start), 8'd1);
        bus.tx_busy = 1'b0;
        @(negedge clk);
        check("busy_low_hold", 8'(bus.tx_start), 8'd1);
        @(negedge clk);
        check("busy_low_hold2", 8'(bus.tx_start), 8'd1);
        finish_tx(0, 2);

        // Asynchronous reset in the middle of WAIT_OP
        send_byte(8'h55);
        send_byte(8'h66);
        idle(2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        rst_n = 1'b1;
        exp_overrun = 1'b0;
        idle(2);
        frame(8'h07, 8'h02, 8'h22, 3);
        check("post_rst_a", bus.alu_a, 8'h07);
        finish_tx(1, 2);

        // Randomized frames
        for (int n = 0; n < 25; n++) begin
            a   = 8'($urandom_range(0, 255));
            b   = 8'($urandom_range(0, 255));
            opb = 8'($urandom_range(0, 255));
            frame(a, b, opb, $urandom_range(0, 12));
            finish_tx($urandom_range(1, 4), $urandom_range(0, 6));
            check("rand_no_timeout", 8'(bus.timeout), 8'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
